// File: rtl/sap_sequencer.sv
// Fetch/execute sequencer for the 8-bit W-bus microcomputer: run/step modes, HALT, opcode-directed T-states.
// Optional macro SEQ_VARIABLE_CYCLE_EN: skip trailing T-states whose control word is pure NOP.
module sap_sequencer #(
  parameter logic [11:0] NOP_WORD = 12'h3e3
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        run,
  input  logic        step,
  input  logic [3:0]  instruction,
  output logic [11:0] cu_out,
  output logic [5:0]  t_state,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state_q, state_d;
  logic   step_q;
  logic   adv;
  logic   op_defined;

  assign adv        = run | (step & ~step_q);
  assign op_defined = (instruction == OP_LDA) || (instruction == OP_ADD) ||
                      (instruction == OP_SUB) || (instruction == OP_OUT) ||
                      (instruction == OP_HLT);

  // Control word and next state; a non-advancing T-state only holds and drives NOP.
  always_comb begin
    cu_out  = NOP_WORD;
    illegal = 1'b0;
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_T1;
      S_T1: if (adv) begin cu_out = 12'h5e3; state_d = S_T2; end
      S_T2: if (adv) begin cu_out = 12'hbe3; state_d = S_T3; end
      S_T3: if (adv) begin cu_out = 12'h263; state_d = S_T4; end
      S_T4: if (adv) begin
        illegal = ~op_defined;
        case (instruction)
          OP_LDA, OP_ADD, OP_SUB: cu_out = 12'h1a3;
          OP_OUT:                 cu_out = 12'h3f2;
          default:                cu_out = NOP_WORD;
        endcase
        if (instruction == OP_HLT) state_d = S_HALT;
`ifdef SEQ_VARIABLE_CYCLE_EN
        else if (instruction == OP_OUT || !op_defined) state_d = S_T1;
`endif
        else state_d = S_T5;
      end
      S_T5: if (adv) begin
        case (instruction)
          OP_LDA:         cu_out = 12'h2c3;
          OP_ADD, OP_SUB: cu_out = 12'h2e1;
          default:        cu_out = NOP_WORD;
        endcase
`ifdef SEQ_VARIABLE_CYCLE_EN
        state_d = (instruction == OP_LDA) ? S_T1 : S_T6;
`else
        state_d = S_T6;
`endif
      end
      S_T6: if (adv) begin
        case (instruction)
          OP_ADD:  cu_out = 12'h3c7;
          OP_SUB:  cu_out = 12'h3cf;
          default: cu_out = NOP_WORD;
        endcase
        state_d = S_T1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step;
    end
  end

  always_comb begin
    case (state_q)
      S_T1:    t_state = 6'b100000;
      S_T2:    t_state = 6'b010000;
      S_T3:    t_state = 6'b001000;
      S_T4:    t_state = 6'b000100;
      S_T5:    t_state = 6'b000010;
      S_T6:    t_state = 6'b000001;
      default: t_state = 6'b000000;
    endcase
  end

  assign halted = (state_q == S_HALT);

endmodule
